// File: rtl/cbus_rr_arbiter.sv
// ============================================================================
// Module   : cbus_rr_arbiter
// Purpose  : Round-robin arbiter sharing one cbus port among NUM_PORTS
//            requesters; each grant covers a whole transaction incl. bursts.
// Options  : define CBUS_ARB_STATS_EN for per-port grant/wait counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  localparam int c_REQ_W  = $bits(cbus_req_t);
  localparam int c_RESP_W = $bits(cbus_resp_t);

endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_PORTS*c_REQ_W-1:0]  ireqs,
  output logic [NUM_PORTS*c_RESP_W-1:0] iresps,
  output logic [c_REQ_W-1:0]            oreq,
  input  logic [c_RESP_W-1:0]           oresp
`ifdef CBUS_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]       stat_grants,
  output logic [NUM_PORTS*32-1:0]       stat_wait
`endif
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_pick;
  logic             w_any;
  logic             w_done;

  logic [NUM_PORTS-1:0] w_valid;
  cbus_req_t            w_req [NUM_PORTS];
  cbus_resp_t           w_resp;

  assign w_resp = cbus_resp_t'(oresp);
  assign w_done = (r_state == S_BUSY) && w_resp.ready && w_resp.last;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign w_req[i]   = cbus_req_t'(ireqs[i*c_REQ_W +: c_REQ_W]);
    assign w_valid[i] = w_req[i].valid;
  end

  // (base + k) mod NUM_PORTS for k in 1..NUM_PORTS; works for any port count.
  function automatic logic [IDX_W-1:0] rr_port(input logic [IDX_W-1:0] base,
                                               input int              k);
    int sum;
    sum = int'(base) + k;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return sum[IDX_W-1:0];
  endfunction

  always_comb begin
    w_any  = 1'b0;
    w_pick = r_ptr;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!w_any && w_valid[rr_port(r_ptr, k)]) begin
        w_any  = 1'b1;
        w_pick = rr_port(r_ptr, k);
      end
    end
  end

  // ptr holds the last port served; reset to the top port so port 0 wins first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_ptr   <= IDX_W'(NUM_PORTS - 1);
    end else if (r_state == S_IDLE) begin
      if (w_any) begin
        r_idx   <= w_pick;
        r_state <= S_BUSY;
      end
    end else if (w_done) begin
      r_state <= S_IDLE;
      r_ptr   <= r_idx;
    end
  end

  assign oreq = (r_state == S_BUSY) ? w_req[r_idx] : '0;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_resp
    assign iresps[i*c_RESP_W +: c_RESP_W] =
      (r_state == S_BUSY && r_idx == IDX_W'(i)) ? w_resp : '0;
  end

`ifdef CBUS_ARB_STATS_EN
  // A port is waiting whenever it is valid and not the active grant, idle cycles included.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stats
    logic [31:0] r_grants;
    logic [31:0] r_wait;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_grants <= '0;
        r_wait   <= '0;
      end else begin
        if (r_state == S_IDLE && w_any && w_pick == IDX_W'(i))
          r_grants <= r_grants + 32'd1;
        if (w_valid[i] && !(r_state == S_BUSY && r_idx == IDX_W'(i)))
          r_wait <= r_wait + 32'd1;
      end
    end

    assign stat_grants[i*32 +: 32] = r_grants;
    assign stat_wait[i*32 +: 32]   = r_wait;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cbus_rr_arbiter.sv
// ============================================================================
// Module   : tb_cbus_rr_arbiter
// Purpose  : Self-checking bench for cbus_rr_arbiter (3 ports, non-power-of-two).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  localparam int NP = 3;

  logic                  clk = 1'b0;
  logic                  resetn;
  cbus_req_t  [NP-1:0]   ireqs;
  cbus_resp_t [NP-1:0]   iresps;
  cbus_req_t             oreq;
  cbus_resp_t            oresp;
`ifdef CBUS_ARB_STATS_EN
  logic [NP*32-1:0]      stat_grants;
  logic [NP*32-1:0]      stat_wait;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: priority list rotated so the port just served goes last.
  int order[$];
  bit m_busy;
  int m_idx;

  cbus_rr_arbiter #(.NUM_PORTS(NP)) dut (
    .clk    (clk),
    .resetn (resetn),
    .ireqs  (ireqs),
    .iresps (iresps),
    .oreq   (oreq),
    .oresp  (oresp)
`ifdef CBUS_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_wait   (stat_wait)
`endif
  );

  always #5 clk = ~clk;

  function automatic cbus_req_t mk_req(input logic [31:0] addr, input logic [3:0] len);
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = 1'($urandom_range(0, 1));
    r.size     = 3'($urandom_range(0, 2));
    r.addr     = addr;
    r.strobe   = 4'($urandom);
    r.data     = $urandom;
    r.len      = len;
    return r;
  endfunction

  function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst);
    cbus_resp_t r;
    r.ready = rdy;
    r.last  = lst;
    r.data  = $urandom;
    return r;
  endfunction

  function automatic void model_reset();
    order.delete();
    for (int i = 0; i < NP; i++) order.push_back(i);
    m_busy = 1'b0;
    m_idx  = 0;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_step();
    bit found;
    found = 1'b0;
    if (!m_busy) begin
      for (int j = 0; j < NP; j++) begin
        if (!found && ireqs[order[j]].valid) begin
          found  = 1'b1;
          m_busy = 1'b1;
          m_idx  = order[j];
        end
      end
    end else if (oresp.ready && oresp.last) begin
      m_busy = 1'b0;
      while (order[$] != m_idx) order.push_back(order.pop_front());
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    ireqs  = '0;
    oresp  = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn   = 1'b0;
    ireqs[0] = mk_req(32'h0000_1000, 4'd0);
    ireqs[2] = mk_req(32'h0000_2000, 4'd0);
    oresp    = mk_resp(1'b1, 1'b1);
    #1;
    n_checks++;
    if (oreq !== '0) $display("FAIL reset_oreq: got %h want 0", oreq);
    else n_pass++;
    n_checks++;
    if (iresps !== '0) $display("FAIL reset_iresps: got %h want 0", iresps);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (oreq !== '0) $display("FAIL reset_hold_oreq: got %h want 0", oreq);
    else n_pass++;
    resetn = 1'b1;
    ireqs  = '0;
    oresp  = '0;
    model_reset();
    @(negedge clk);
    #1;
    n_checks++;
    if (oreq !== '0) $display("FAIL reset_release_oreq: got %h want 0", oreq);
    else n_pass++;
  endtask

  task automatic test_single_beat();
    cbus_req_t r0;
    do_reset();
    r0 = mk_req(32'h1fc0_0000, 4'd0);
    @(negedge clk);
    ireqs[0] = r0;
    #1;
    n_checks++;
    if (oreq !== '0) $display("FAIL single_latency: got %h want 0", oreq);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (oreq.valid !== 1'b1 || oreq.addr !== 32'h1fc0_0000 || oreq !== r0)
      $display("FAIL single_oreq: got %h want %h", oreq, r0);
    else n_pass++;
    @(negedge clk);
    oresp = mk_resp(1'b1, 1'b1);
    #1;
    n_checks++;
    if (iresps[0] !== oresp || iresps[0].last !== 1'b1)
      $display("FAIL single_iresp0: got %h want %h", iresps[0], oresp);
    else n_pass++;
    n_checks++;
    if (iresps[1] !== '0 || iresps[2] !== '0)
      $display("FAIL single_other_iresps: got %h %h want 0", iresps[1], iresps[2]);
    else n_pass++;
    // Request and ready stay high: idle gap must still occur, ready ignored.
    @(negedge clk);
    #1;
    n_checks++;
    if (oreq !== '0 || iresps !== '0)
      $display("FAIL single_gap: got oreq %h iresps %h want 0", oreq, iresps);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (oreq !== r0) $display("FAIL single_regrant: got %h want %h", oreq, r0);
    else n_pass++;
    @(negedge clk);
    ireqs = '0;
    oresp = '0;
  endtask

  // nv ports always valid, single-beat responses: grants rotate with one idle cycle between.
  task automatic test_rotation(input int nv);
    cbus_req_t want;
    do_reset();
    @(negedge clk);
    for (int p = 0; p < nv; p++) ireqs[p] = mk_req(32'h8000_0000 + 32'(p * 16), 4'd0);
    oresp = mk_resp(1'b1, 1'b1);
    for (int c = 0; c < 4 * nv + 2; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      want = (c % 2 == 0) ? '0 : ireqs[((c - 1) / 2) % nv];
      n_checks++;
      if (oreq !== want)
        $display("FAIL rotation%0d_c%0d: got %h want %h", nv, c, oreq, want);
      else n_pass++;
    end
    @(negedge clk);
    ireqs = '0;
    oresp = '0;
  endtask

  task automatic test_burst();
    cbus_req_t r0, r1;
    do_reset();
    r0 = mk_req(32'h0000_0400, 4'd0);
    r1 = mk_req(32'h0000_0800, 4'd3);
    @(negedge clk);
    ireqs[1] = r1;
    #1;
    n_checks++;
    if (oreq !== '0) $display("FAIL burst_idle: got %h want 0", oreq);
    else n_pass++;
    for (int b = 1; b <= 5; b++) begin
      @(negedge clk);
      if (b == 2) ireqs[0] = r0;
      oresp = (b == 3) ? mk_resp(1'b0, 1'b0) : mk_resp(1'b1, b == 5);
      #1;
      n_checks++;
      if (oreq !== r1) $display("FAIL burst_oreq_b%0d: got %h want %h", b, oreq, r1);
      else n_pass++;
      n_checks++;
      if (iresps[1] !== oresp || iresps[0] !== '0)
        $display("FAIL burst_iresps_b%0d: got %h/%h want %h/0", b, iresps[1], iresps[0], oresp);
      else n_pass++;
    end
    @(negedge clk);
    ireqs[1] = '0;
    oresp    = '0;
    #1;
    n_checks++;
    if (oreq !== '0) $display("FAIL burst_gap: got %h want 0", oreq);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (oreq !== r0) $display("FAIL burst_next_grant: got %h want %h", oreq, r0);
    else n_pass++;
    @(negedge clk);
    ireqs = '0;
  endtask

  task automatic test_reset_midburst();
    cbus_req_t r0, r1;
    do_reset();
    r0 = mk_req(32'h0000_0c00, 4'd0);
    r1 = mk_req(32'h0000_0d00, 4'd3);
    // Serve port 0 first so that, without a pointer reset, port 1 would lead.
    @(negedge clk);
    ireqs[0] = r0;
    @(negedge clk);
    oresp = mk_resp(1'b1, 1'b1);
    @(negedge clk);
    ireqs[0] = '0;
    ireqs[1] = r1;
    oresp    = '0;
    @(negedge clk);
    oresp = mk_resp(1'b1, 1'b0);
    @(negedge clk);
    oresp = mk_resp(1'b1, 1'b0);
    #1;
    n_checks++;
    if (oreq !== r1) $display("FAIL midrst_busy: got %h want %h", oreq, r1);
    else n_pass++;
    #1;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (oreq !== '0 || iresps !== '0)
      $display("FAIL midrst_async: got oreq %h iresps %h want 0", oreq, iresps);
    else n_pass++;
    @(negedge clk);
    ireqs[0] = r0;
    oresp    = '0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_checks++;
    if (oreq !== '0) $display("FAIL midrst_release: got %h want 0", oreq);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (oreq !== r0) $display("FAIL midrst_priority: got %h want %h", oreq, r0);
    else n_pass++;
    @(negedge clk);
    ireqs = '0;
  endtask

`ifdef CBUS_ARB_STATS_EN
  task automatic test_stats();
    int exp_wait [NP];
    int exp_grant [NP];
    bit was_busy;
    do_reset();
    @(negedge clk);
    #1;
    n_checks++;
    if (stat_grants !== '0 || stat_wait !== '0)
      $display("FAIL stats_reset: got %h/%h want 0", stat_grants, stat_wait);
    else n_pass++;
    for (int p = 0; p < NP; p++) begin
      exp_wait[p]  = 0;
      exp_grant[p] = 0;
    end
    @(negedge clk);
    ireqs[0] = mk_req(32'h0000_0100, 4'd0);
    ireqs[1] = mk_req(32'h0000_0200, 4'd0);
    oresp    = mk_resp(1'b1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      for (int p = 0; p < NP; p++)
        if (ireqs[p].valid && !(m_busy && m_idx == p)) exp_wait[p]++;
      was_busy = m_busy;
      model_step();
      if (!was_busy && m_busy) exp_grant[m_idx]++;
    end
    @(negedge clk);
    ireqs = '0;
    oresp = '0;
    #1;
    for (int p = 0; p < NP; p++) begin
      n_checks++;
      if (stat_grants[p*32 +: 32] !== 32'(exp_grant[p]) || (p < 2 && exp_grant[p] != 5))
        $display("FAIL stats_grants_p%0d: got %0d want %0d", p, stat_grants[p*32 +: 32], exp_grant[p]);
      else n_pass++;
      n_checks++;
      if (stat_wait[p*32 +: 32] !== 32'(exp_wait[p]))
        $display("FAIL stats_wait_p%0d: got %0d want %0d", p, stat_wait[p*32 +: 32], exp_wait[p]);
      else n_pass++;
    end
  endtask
`endif

  task automatic test_random();
    bit         done [NP];
    cbus_req_t  exp_req;
    cbus_resp_t exp_resp;
    do_reset();
    for (int p = 0; p < NP; p++) done[p] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (done[p]) begin
          ireqs[p] = '0;
          done[p]  = 1'b0;
        end else if (!ireqs[p].valid && $urandom_range(0, 3) == 0) begin
          ireqs[p] = mk_req($urandom, 4'($urandom_range(0, 7)));
        end
      end
      oresp = mk_resp($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
      #1;
      exp_req = m_busy ? ireqs[m_idx] : '0;
      n_checks++;
      if (oreq !== exp_req)
        $display("FAIL rand_oreq cyc %0d: got %h want %h", cyc, oreq, exp_req);
      else n_pass++;
      for (int p = 0; p < NP; p++) begin
        exp_resp = (m_busy && m_idx == p) ? oresp : '0;
        n_checks++;
        if (iresps[p] !== exp_resp)
          $display("FAIL rand_iresp%0d cyc %0d: got %h want %h", p, cyc, iresps[p], exp_resp);
        else n_pass++;
      end
      if (m_busy && oresp.ready && oresp.last) done[m_idx] = 1'b1;
      model_step();
    end
    @(negedge clk);
    ireqs = '0;
    oresp = '0;
  endtask

  initial begin
    resetn = 1'b0;
    ireqs  = '0;
    oresp  = '0;
    model_reset();
    test_reset();
    test_single_beat();
    test_rotation(2);
    test_rotation(3);
    test_burst();
    test_reset_midburst();
`ifdef CBUS_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cbus_rr_arbiter.md
Name: cbus_rr_arbiter

Overview:
- N-port round-robin arbiter sharing the single outbound cached-bus (cbus) port between requesters: instruction-fetch converter, data converter, and any later uncached/DMA path.
- Sits between the IBus/DBus-to-CBus converters and the address-translation stage in the top-level wrapper.
- Grants one full cbus transaction, including all burst beats, at a time.
- One-cycle registered arbitration; fair rotation so no requester starves.

Parameters:
- NUM_PORTS, 2, number of cbus requesters; 2..8.
- IDX_W, $clog2(NUM_PORTS), width of the grant index; derived, do not override.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; asynchronous, active-low.
- ireqs  in  cbus_req_t x NUM_PORTS  requester-side cbus requests; index 0 is listed first.
- iresps  out  cbus_resp_t x NUM_PORTS  per-requester cbus responses.
- oreq  out  cbus_req_t  request forwarded to the memory side.
- oresp  in  cbus_resp_t  memory-side response (ready, last, data).

Behaviour:
- Clock, reset: clk, resetn. Reset is asynchronous, active-low; all state clears immediately on resetn low.
- Reset values:
  - state = IDLE, idx = 0, ptr = NUM_PORTS-1, so port 0 wins first.
  - oreq = '0; every iresps[i] = '0.
- State machine: IDLE, BUSY.
- IDLE:
  - oreq = '0; all iresps = '0.
  - If any ireqs[i].valid, pick the first valid port scanning ptr+1, ptr+2, ... modulo NUM_PORTS. Latch it into idx; next state BUSY.
  - If no port is valid, stay in IDLE.
- BUSY:
  - oreq = ireqs[idx] combinationally, all fields including valid, is_write, size, addr, strobe, data, len.
  - iresps[idx] = oresp; every other iresps[j] = '0.
- Transaction end: oresp.ready && oresp.last in BUSY.
  - Next state IDLE; ptr <= idx.
  - A new grant is decided in the following IDLE cycle. Minimum gap between back-to-back transactions is 1 idle cycle.
- Latency: a request first seen valid in cycle t appears on oreq in cycle t+1 if the arbiter is idle.
- Bursts: beats with ready && !last keep the grant; len is never inspected.
- Simultaneous requests: resolved purely by the rotation order from ptr+1. With 2 ports both always valid, grants alternate 0,1,0,1...
- Requester drops valid while BUSY: protocol violation. The arbiter stays BUSY, oreq.valid follows the requester, and no grant change occurs until ready && last.
- Non-granted requesters: their valid is ignored and their responses are held at zero. They must hold the request stable until granted.
- oresp.ready while IDLE: ignored, no state change.
- Reset asserted mid-burst: immediate return to IDLE with the reset values above. The downstream side must also be reset.
- All index arithmetic is modulo NUM_PORTS; wrap from NUM_PORTS-1 to 0 when NUM_PORTS is not a power of two.

Optional Feature:
- CBUS_ARB_STATS_EN defined adds outputs:
  - stat_grants, out, 32 x NUM_PORTS: per-port count of grants, +1 on each IDLE->BUSY for that port.
  - stat_wait, out, 32 x NUM_PORTS: per-port count of cycles that port had valid but was not the current grant.
- Counters wrap at 2^32, reset to 0, never saturate.
- Without the macro, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, port 0 valid at cycle 2 with addr 0x1fc00000, len 0 -> oreq.valid=1, addr=0x1fc00000 at cycle 3. Single beat oresp ready=1, last=1 at cycle 4 -> IDLE at cycle 5, iresps[0].last=1 only in cycle 4.
- Ports 0 and 1 both valid continuously, single beats -> grant order 0,1,0,1, one idle cycle between each.
- Port 1 burst of 4 beats (len=3), port 0 raised valid at beat 2 -> oreq stays port 1 until 4th beat with last. Port 0 is granted the next cycle; iresps[0] = 0 throughout the burst.
- resetn low during beat 2 of a 4-beat burst -> oreq = '0 immediately (asynchronous), state IDLE. After release, port 0 has priority.
- NUM_PORTS=3, all valid, after port 2 served -> next grant port 0 (wrap).
- With CBUS_ARB_STATS_EN, 2 ports always valid, 10 single-beat transactions -> stat_grants = {5,5}; stat_wait accumulates only on the non-granted port.
